// File: rtl/seq_shift_add_multiplier.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier.
// One WIDTH-bit ripple-carry adder is reused for every step. Each operation
// takes WIDTH RUN cycles, and a valid/ready handshake sits on both sides.

// One-bit full adder cell. Each adder bit position uses one instance.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// N-bit ripple-carry adder built as a chain of full_adder instances.
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;

    // Carry ripples from bit 0 upward.
    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[N];
endmodule

module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    // The counter needs at least one bit so that WIDTH=1 stays legal.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;

    logic accept;
    logic deliver;

    assign accept  = in_valid  && (state == IDLE);
    assign deliver = out_ready && (state == DONE);

    // The low accumulator bit is the current multiplier bit. It decides
    // whether the multiplicand is added in on this step.
    assign addend = acc_lo[0] ? mcand : '0;

    ripple_carry_adder #(.N(WIDTH)) u_add (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode. RUN ends on the step where count has reached zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)       state_nxt = RUN;
            RUN:     if (count == '0)  state_nxt = DONE;
            DONE:    if (deliver)      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Datapath: load the operands on accept, then shift-add once per RUN cycle.
    // {cout, sum} is WIDTH+1 bits wide. Shifting it together with acc_lo
    // keeps the carry of every step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mcand  <= a;
                    acc_lo <= b;
                    acc_hi <= '0;
                    count  <= CW'(WIDTH - 1);
                end
                RUN: begin
                    {acc_hi, acc_lo} <= (2*WIDTH)'({cout, sum, acc_lo} >> 1);
                    if (count != '0) count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state and registers only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        product   = {acc_hi, acc_lo};
    end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and random checks of seq_shift_add_multiplier at WIDTH 4, 1 and 8.
module tb_seq_shift_add_multiplier;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main WIDTH=4 instance.
    logic         iv, ir, ov, ordy;
    logic [W-1:0] a4, b4;
    logic [2*W-1:0] p4;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
        .a(a4), .b(b4), .out_valid(ov), .out_ready(ordy), .product(p4)
    );

    // WIDTH=1 and WIDTH=8 instances share their stimulus, selected by sel8.
    logic        sel8, iv_s;
    logic [7:0]  a_s, b_s;
    logic        iv1, ir1, ov1, iv8, ir8, ov8;
    logic [1:0]  p1;
    logic [15:0] p8;

    assign iv1 = iv_s && !sel8;
    assign iv8 = iv_s &&  sel8;

    seq_shift_add_multiplier #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a_s[0]), .b(b_s[0]), .out_valid(ov1), .out_ready(ordy), .product(p1)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a_s), .b(b_s), .out_valid(ov8), .out_ready(ordy), .product(p8)
    );

    logic        ov_s, ir_s;
    logic [15:0] p_s;
    assign ov_s = sel8 ? ov8 : ov1;
    assign ir_s = sel8 ? ir8 : ir1;
    assign p_s  = sel8 ? p8  : {14'b0, p1};

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 operation. hold = number of extra cycles out_ready stays low.
    // During the hold, a/b change and in_valid pulses, and both must be ignored.
    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input int hold);
        ordy = (hold == 0);
        a4 = a; b4 = b; iv = 1'b1;
        check("ready_before_accept", 16'(ir), 16'd1);
        tick;                              // accept edge T
        iv = 1'b0;
        check("ready_drop", 16'(ir), 16'd0);
        for (int k = 1; k < W; k++) begin
            tick;
            check("latency_early", 16'(ov), 16'd0);
        end
        tick;                              // edge T+W
        check("out_valid", 16'(ov), 16'd1);
        check("product", 16'(p4), 16'(exp));
        for (int h = 0; h < hold; h++) begin
            a4 = ~a4; b4 = b4 + 4'd1; iv = 1'b1;
            tick;
            check("hold_valid", 16'(ov), 16'd1);
            check("hold_product", 16'(p4), 16'(exp));
            check("hold_ready", 16'(ir), 16'd0);
        end
        iv = 1'b0;
        ordy = 1'b1;
        tick;                              // transfer edge
        check("post_valid", 16'(ov), 16'd0);
        check("post_ready", 16'(ir), 16'd1);
    endtask

    // One operation on the WIDTH=1 or WIDTH=8 instance.
    task automatic runs(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
        ordy = 1'b1;
        a_s = a; b_s = b; iv_s = 1'b1;
        tick;
        iv_s = 1'b0;
        check("s_ready_drop", 16'(ir_s), 16'd0);
        for (int k = 1; k < w; k++) begin
            tick;
            check("s_latency_early", 16'(ov_s), 16'd0);
        end
        tick;
        check("s_out_valid", 16'(ov_s), 16'd1);
        check("s_product", p_s, exp);
        tick;
        check("s_post_valid", 16'(ov_s), 16'd0);
        check("s_post_ready", 16'(ir_s), 16'd1);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        int         hold;
    } vec_t;

    vec_t vt[10];

    initial begin
        // Hand-computed products.
        vt[0] = '{4'd5,  4'd3,  8'h0F, 0};
        vt[1] = '{4'd15, 4'd15, 8'hE1, 0};
        vt[2] = '{4'd0,  4'd9,  8'h00, 0};
        vt[3] = '{4'd9,  4'd0,  8'h00, 0};
        vt[4] = '{4'd7,  4'd6,  8'h2A, 5};
        vt[5] = '{4'd2,  4'd3,  8'h06, 0};
        vt[6] = '{4'd1,  4'd1,  8'h01, 0};
        vt[7] = '{4'd15, 4'd1,  8'h0F, 2};
        vt[8] = '{4'd8,  4'd8,  8'h40, 0};
        vt[9] = '{4'd10, 4'd13, 8'h82, 0};

        iv = 1'b0; a4 = '0; b4 = '0; ordy = 1'b1;
        sel8 = 1'b0; iv_s = 1'b0; a_s = '0; b_s = '0;

        // Values while reset is held.
        rst_n = 1'b0;
        #1;
        check("reset_valid", 16'(ov), 16'd0);
        check("reset_product", 16'(p4), 16'd0);
        #20;
        rst_n = 1'b1;
        tick;
        check("reset_ready", 16'(ir), 16'd1);
        check("reset_valid_after", 16'(ov), 16'd0);

        for (int i = 0; i < 10; i++)
            run4(vt[i].a, vt[i].b, vt[i].p, vt[i].hold);

        // Asynchronous reset during the second RUN cycle.
        a4 = 4'd12; b4 = 4'd11; iv = 1'b1;
        tick;
        iv = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        check("midop_reset_valid", 16'(ov), 16'd0);
        check("midop_reset_product", 16'(p4), 16'd0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < W + 3; k++) begin
            tick;
            check("midop_no_output", 16'(ov), 16'd0);
            check("midop_ready", 16'(ir), 16'd1);
        end
        run4(4'd2, 4'd3, 8'h06, 0);

        // Back-to-back: in_valid and out_ready held high, so accepts are
        // spaced WIDTH+2 cycles apart.
        begin
            logic [3:0] ra, rb;
            logic [7:0] pexp;
            ordy = 1'b1;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            a4 = ra; b4 = rb; iv = 1'b1;
            for (int n = 0; n < 4; n++) begin
                pexp = 8'(ra) * 8'(rb);
                tick;                              // accept
                check("b2b_accept", 16'(ir), 16'd0);
                ra = 4'($urandom_range(0, 15));
                rb = 4'($urandom_range(0, 15));
                a4 = ra; b4 = rb;
                for (int k = 1; k < W; k++) begin
                    tick;
                    check("b2b_early", 16'(ov), 16'd0);
                end
                tick;
                check("b2b_valid", 16'(ov), 16'd1);
                check("b2b_product", 16'(p4), 16'(pexp));
                tick;                              // transfer
                check("b2b_idle", 16'(ir), 16'd1);
            end
            tick;                                  // final accept under tied in_valid
            iv = 1'b0;
            repeat (W + 1) tick;
            tick;
            check("b2b_drain", 16'(ir), 16'd1);
        end

        // Random WIDTH=4 vectors.
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom);
            rb = 4'($urandom);
            run4(ra, rb, 8'(ra) * 8'(rb), 0);
        end

        // WIDTH=1
        sel8 = 1'b0;
        runs(1, 8'd1, 8'd1, 16'h0001);
        runs(1, 8'd1, 8'd0, 16'h0000);
        for (int i = 0; i < 1000; i++) begin
            logic ra, rb;
            ra = 1'($urandom);
            rb = 1'($urandom);
            runs(1, {7'b0, ra}, {7'b0, rb}, {15'b0, ra & rb});
        end

        // WIDTH=8
        sel8 = 1'b1;
        tick;
        runs(8, 8'hFF, 8'hFF, 16'hFE01);
        runs(8, 8'h80, 8'h02, 16'h0100);
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            runs(8, ra, rb, 16'(ra) * 16'(rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
